// File: rtl/vga_mixer_pkg.sv
// vga_mixer_pkg: shared fade-state encoding and level constants for the layer mixer
package vga_mixer_pkg;

    typedef enum logic [1:0] {
        FULL     = 2'd0,
        FADE_OUT = 2'd1,
        BLACK    = 2'd2,
        FADE_IN  = 2'd3
    } fade_state_e;

    localparam int LVL_W = 4;
    localparam logic [LVL_W-1:0] LVL_MAX = 4'd15;

endpackage

// File: rtl/mixer_fade_ctrl.sv
// mixer_fade_ctrl: fade FSM, ms step counter, level and frame-synchronous applied level
module mixer_fade_ctrl
    import vga_mixer_pkg::*;
#(
    parameter int FADE_STEP_MS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             one_ms_tick,
    input  logic             fade_out_req,
    input  logic             fade_in_req,
    input  logic             vblnk_in,
    output logic [LVL_W-1:0] level_applied,
    output logic             fade_done
);

    localparam int CW = $clog2(FADE_STEP_MS + 1);

    fade_state_e      state_q, state_d;
    logic [CW-1:0]    ms_q, ms_d;
    logic [LVL_W-1:0] level_q, level_d, applied_q, applied_d;
    logic             done_q, done_d, vblnk_q;
    logic             fading, step;

    // next state: requests take precedence over steps; a state change restarts the ms counter
    always_comb begin
        fading    = (state_q == FADE_OUT) || (state_q == FADE_IN);
        step      = fading && one_ms_tick && (ms_q == CW'(FADE_STEP_MS - 1));
        state_d   = state_q;
        level_d   = level_q;
        done_d    = 1'b0;
        ms_d      = (fading && one_ms_tick) ? (step ? '0 : ms_q + CW'(1)) : ms_q;
        if (fade_out_req && (state_q == FULL || state_q == FADE_IN)) begin
            state_d = FADE_OUT;
        end else if (fade_in_req && !fade_out_req && (state_q == BLACK || state_q == FADE_OUT)) begin
            state_d = FADE_IN;
        end else if (step && state_q == FADE_OUT) begin
            level_d = (level_q == '0) ? level_q : level_q - LVL_W'(1);
            if (level_q <= LVL_W'(1)) begin
                state_d = BLACK;
                done_d  = 1'b1;
            end
        end else if (step && state_q == FADE_IN) begin
            level_d = (level_q == LVL_MAX) ? level_q : level_q + LVL_W'(1);
            if (level_q >= LVL_MAX - LVL_W'(1)) begin
                state_d = FULL;
                done_d  = 1'b1;
            end
        end
        ms_d      = (state_d != state_q) ? '0 : ms_d;
        applied_d = (vblnk_in && !vblnk_q) ? level_q : applied_q;
    end

    // state, counter and level registers; reset returns to full brightness
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FULL;
            ms_q      <= '0;
            level_q   <= LVL_MAX;
            applied_q <= LVL_MAX;
            done_q    <= 1'b0;
            vblnk_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ms_q      <= ms_d;
            level_q   <= level_d;
            applied_q <= applied_d;
            done_q    <= done_d;
            vblnk_q   <= vblnk_in;
        end
    end

    assign level_applied = applied_q;
    assign fade_done     = done_q;

endmodule

// File: rtl/vga_layer_mixer.sv
// vga_layer_mixer: 3-stage priority compositor with frame-synchronous fade and matched timing
module vga_layer_mixer
    import vga_mixer_pkg::*;
#(
    parameter int LAYERS       = 6,
    parameter int CH_W         = 4,
    parameter int FADE_STEP_MS = 32,
    parameter int CNT_W        = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CNT_W-1:0]           hcount_in,
    input  logic [CNT_W-1:0]           vcount_in,
    input  logic                       hsync_in,
    input  logic                       vsync_in,
    input  logic                       hblnk_in,
    input  logic                       vblnk_in,
    input  logic [3*CH_W-1:0]          bg_rgb,
    input  logic [LAYERS*3*CH_W-1:0]   layer_rgb,
    input  logic [LAYERS-1:0]          layer_valid,
    input  logic [LAYERS-1:0]          layer_en,
    input  logic                       one_ms_tick,
    input  logic                       fade_out_req,
    input  logic                       fade_in_req,
    output logic [CNT_W-1:0]           hcount_out,
    output logic [CNT_W-1:0]           vcount_out,
    output logic                       hsync_out,
    output logic                       vsync_out,
    output logic                       hblnk_out,
    output logic                       vblnk_out,
    output logic [3*CH_W-1:0]          rgb_out,
    output logic                       fade_done
);

    localparam int RGB_W = 3 * CH_W;
    localparam int TW    = 2 * CNT_W + 4;

    logic [TW-1:0]           tim1_q, tim1_d, tim2_q, tim2_d, tim3_q, tim3_d;
    logic [RGB_W-1:0]        bg1_q, bg1_d, rgb2_q, rgb2_d, rgb3_q, rgb3_d;
    logic [LAYERS*RGB_W-1:0] lay1_q, lay1_d;
    logic [LAYERS-1:0]       hit1_q, hit1_d;
    logic [LVL_W-1:0]        lvl;
    logic [CH_W+3:0]         prod;

    mixer_fade_ctrl #(.FADE_STEP_MS(FADE_STEP_MS)) u_fade (
        .clk          (clk),
        .rst          (rst),
        .one_ms_tick  (one_ms_tick),
        .fade_out_req (fade_out_req),
        .fade_in_req  (fade_in_req),
        .vblnk_in     (vblnk_in),
        .level_applied(lvl),
        .fade_done    (fade_done)
    );

    // S1 capture with hit mask, S2 priority pick (highest index wins), S3 scale and blank
    always_comb begin
        tim1_d = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
        bg1_d  = bg_rgb;
        lay1_d = layer_rgb;
        hit1_d = layer_en & layer_valid;
        tim2_d = tim1_q;
        rgb2_d = bg1_q;
        for (int i = 0; i < LAYERS; i++)
            rgb2_d = hit1_q[i] ? lay1_q[i*RGB_W +: RGB_W] : rgb2_d;
        tim3_d = tim2_q;
        rgb3_d = '0;
        prod   = '0;
        for (int k = 0; k < 3; k++) begin
            prod = (CH_W+4)'(rgb2_q[k*CH_W +: CH_W]) * ((CH_W+4)'(lvl) + (CH_W+4)'(1));
            rgb3_d[k*CH_W +: CH_W] = CH_W'(prod >> 4);
        end
        rgb3_d = (tim2_q[1] || tim2_q[0]) ? '0 : rgb3_d;
    end

    // pipeline registers; reset flushes every stage to zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tim1_q <= '0;
            tim2_q <= '0;
            tim3_q <= '0;
            bg1_q  <= '0;
            lay1_q <= '0;
            hit1_q <= '0;
            rgb2_q <= '0;
            rgb3_q <= '0;
        end else begin
            tim1_q <= tim1_d;
            tim2_q <= tim2_d;
            tim3_q <= tim3_d;
            bg1_q  <= bg1_d;
            lay1_q <= lay1_d;
            hit1_q <= hit1_d;
            rgb2_q <= rgb2_d;
            rgb3_q <= rgb3_d;
        end
    end

    assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = tim3_q;
    assign rgb_out = rgb3_q;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// tb_vga_layer_mixer: directed and random stimulus checked against a behavioural compositor/fade model
module tb_vga_layer_mixer;

    localparam int LAYERS = 6;
    localparam int CH_W   = 4;
    localparam int STEP   = 2;
    localparam int CNT_W  = 11;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [CNT_W-1:0]      hcount_in = '0, vcount_in = '0;
    logic                  hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0]           bg_rgb = '0;
    logic [LAYERS*12-1:0]  layer_rgb = '0;
    logic [LAYERS-1:0]     layer_valid = '0, layer_en = '0;
    logic                  one_ms_tick = 1'b0, fade_out_req = 1'b0, fade_in_req = 1'b0;
    logic [CNT_W-1:0]      hcount_out, vcount_out;
    logic                  hsync_out, vsync_out, hblnk_out, vblnk_out, fade_done;
    logic [11:0]           rgb_out;

    vga_layer_mixer #(.LAYERS(LAYERS), .CH_W(CH_W), .FADE_STEP_MS(STEP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .bg_rgb(bg_rgb), .layer_rgb(layer_rgb), .layer_valid(layer_valid), .layer_en(layer_en),
        .one_ms_tick(one_ms_tick), .fade_out_req(fade_out_req), .fade_in_req(fade_in_req),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .fade_done(fade_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit               zero;
        logic [CNT_W-1:0] hc, vc;
        logic             hs, vs, hb, vb;
        logic [11:0]      col;
    } ent_t;

    ent_t ent[4];
    int   app_h[4];
    int   cyc = 4;
    int   tests = 0, fails = 0, done_seen = 0;
    int   level = 15, dir = 0, ms = 0, applied = 15;
    bit   vprev = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [11:0] scale(input logic [11:0] c, input int l);
        logic [11:0] r;
        for (int k = 0; k < 3; k++) r[k*4 +: 4] = 4'((int'(c[k*4 +: 4]) * (l + 1)) / 16);
        return r;
    endfunction

    // model this cycle's capture, advance one clock, then check the pixel captured two edges ago
    task automatic cyc_step();
        int          i;
        bit          done, changed;
        ent_t        e;
        logic [37:0] exp_v;
        i = cyc & 3;
        done = 0;
        changed = 0;
        if (!rst) begin
            level = 15; dir = 0; ms = 0; applied = 15; vprev = 0;
            ent[i].zero = 1; ent[(cyc-1) & 3].zero = 1; ent[(cyc-2) & 3].zero = 1;
        end else begin
            ent[i].zero = 0;
            ent[i].hc = hcount_in; ent[i].vc = vcount_in;
            ent[i].hs = hsync_in; ent[i].vs = vsync_in; ent[i].hb = hblnk_in; ent[i].vb = vblnk_in;
            ent[i].col = bg_rgb;
            for (int j = 0; j < LAYERS; j++)
                if (layer_en[j] && layer_valid[j]) ent[i].col = layer_rgb[j*12 +: 12];
            if (vblnk_in && !vprev) applied = level;
            vprev = vblnk_in;
            if (fade_out_req) begin
                if (dir != -1 && !(dir == 0 && level == 0)) begin dir = -1; ms = 0; changed = 1; end
            end else if (fade_in_req) begin
                if (dir != 1 && !(dir == 0 && level == 15)) begin dir = 1; ms = 0; changed = 1; end
            end
            if (!changed && dir != 0 && one_ms_tick) begin
                ms++;
                if (ms == STEP) begin
                    ms = 0;
                    level = level + dir;
                    if (level < 0) level = 0;
                    if (level > 15) level = 15;
                    if ((dir < 0 && level == 0) || (dir > 0 && level == 15)) begin dir = 0; done = 1; end
                end
            end
        end
        app_h[i] = applied;
        @(posedge clk);
        #1;
        e = ent[(cyc-2) & 3];
        exp_v = e.zero ? 38'h0 : {e.hc, e.vc, e.hs, e.vs, e.hb, e.vb,
                                  (e.hb || e.vb) ? 12'h0 : scale(e.col, app_h[(cyc-1) & 3])};
        chk("pipe", {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out}, exp_v);
        chk("fade_done", fade_done, done);
        done_seen += int'(fade_done);
        cyc++;
    endtask

    task automatic rand_pix();
        layer_rgb   = (LAYERS*12)'({$urandom, $urandom, $urandom});
        layer_valid = LAYERS'($urandom);
        layer_en    = LAYERS'($urandom);
        bg_rgb      = 12'($urandom);
        hcount_in   = CNT_W'($urandom);
        vcount_in   = CNT_W'($urandom);
        hsync_in    = 1'($urandom);
        vsync_in    = 1'($urandom);
        hblnk_in    = ($urandom % 8) == 0;
    endtask

    task automatic frame();
        for (int j = 0; j < 4; j++) begin rand_pix(); vblnk_in = 0; cyc_step(); end
        one_ms_tick = 1; rand_pix(); cyc_step(); one_ms_tick = 0;
        vblnk_in = 1; rand_pix(); cyc_step(); cyc_step(); vblnk_in = 0;
    endtask

    task automatic solid(input int n);
        layer_en = '0; bg_rgb = 12'hFFF; hblnk_in = 0; vblnk_in = 0;
        for (int j = 0; j < n; j++) cyc_step();
    endtask

    initial begin
        for (int j = 0; j < 4; j++) begin ent[j].zero = 1; app_h[j] = 15; end
        #2 rst = 0;
        // reset holds every output at zero
        for (int j = 0; j < 5; j++) cyc_step();
        chk("rst_rgb", rgb_out, 12'h000);
        chk("rst_timing", {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, 26'h0);
        chk("rst_done", fade_done, 1'b0);
        rst = 1; bg_rgb = 12'h0F0;
        for (int j = 0; j < 3; j++) cyc_step();
        chk("bg_only", rgb_out, 12'h0F0);
        // priority: layer 4 beats layer 1, then layer 1 once layer 4 is disabled
        layer_en = 6'h3F; layer_valid = 6'b010010;
        layer_rgb[4*12 +: 12] = 12'hF00; layer_rgb[1*12 +: 12] = 12'h0A5;
        for (int j = 0; j < 3; j++) cyc_step();
        chk("prio_l4", rgb_out, 12'hF00);
        layer_en[4] = 0;
        for (int j = 0; j < 3; j++) cyc_step();
        chk("prio_l1", rgb_out, 12'h0A5);
        // hsync latency of exactly three clocks
        hsync_in = 1; cyc_step(); hsync_in = 0;
        cyc_step(); chk("hsync_n2", hsync_out, 1'b0);
        cyc_step(); chk("hsync_n3", hsync_out, 1'b1);
        cyc_step(); chk("hsync_n4", hsync_out, 1'b0);
        // horizontal blank masks a valid layer
        hblnk_in = 1;
        for (int j = 0; j < 3; j++) cyc_step();
        chk("hblank", rgb_out, 12'h000);
        hblnk_in = 0;
        // random pixels at full level
        for (int j = 0; j < 150; j++) begin
            rand_pix();
            vblnk_in = ($urandom % 4) == 0;
            one_ms_tick = ($urandom % 3) == 0;
            cyc_step();
        end
        vblnk_in = 0; one_ms_tick = 0;
        // fade out to black
        done_seen = 0;
        fade_out_req = 1; cyc_step(); fade_out_req = 0;
        for (int j = 0; j < 8; j++) frame();
        solid(4); chk("fade_l11", rgb_out, 12'hBBB);
        for (int j = 0; j < 24; j++) frame();
        solid(4); chk("fade_black", rgb_out, 12'h000);
        chk("out_done_cnt", done_seen, 1);
        // ignored request in black
        fade_out_req = 1; cyc_step(); fade_out_req = 0;
        frame(); frame();
        // fade in to full
        done_seen = 0;
        fade_in_req = 1; cyc_step(); fade_in_req = 0;
        for (int j = 0; j < 32; j++) frame();
        solid(4); chk("fade_full", rgb_out, 12'hFFF);
        chk("in_done_cnt", done_seen, 1);
        // reversal mid-fade
        done_seen = 0;
        fade_out_req = 1; cyc_step(); fade_out_req = 0;
        for (int j = 0; j < 6; j++) frame();
        solid(4); chk("rev_l12", rgb_out, 12'hCCC);
        chk("rev_no_done", done_seen, 0);
        fade_in_req = 1; cyc_step(); fade_in_req = 0;
        for (int j = 0; j < 6; j++) frame();
        solid(4); chk("rev_full", rgb_out, 12'hFFF);
        chk("rev_done_cnt", done_seen, 1);
        // simultaneous requests in full: fade out wins
        fade_out_req = 1; fade_in_req = 1; cyc_step(); fade_out_req = 0; fade_in_req = 0;
        for (int j = 0; j < 2; j++) frame();
        solid(4); chk("both_l14", rgb_out, 12'hEEE);
        for (int j = 0; j < 14; j++) frame();
        solid(4); chk("pre_rst_l7", rgb_out, 12'h777);
        // reset mid-fade
        rst = 0;
        for (int j = 0; j < 3; j++) cyc_step();
        chk("midrst_rgb", rgb_out, 12'h000);
        rst = 1;
        solid(4); chk("post_rst_full", rgb_out, 12'hFFF);
        for (int j = 0; j < 20; j++) frame();
        solid(4); chk("post_rst_idle", rgb_out, 12'hFFF);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
